luma_arbiter: RTL and testbench

Shares one sequential luma (grayscale) engine between two pixel requesters: requester 0 is the live camera path, requester 1 is the frame-buffer readback path. The block arbitrates between them and sequences a single multiply-accumulate through the R, G and B terms. It returns a 10-bit luma value tagged with the requester ID over a valid/ready handshake. It sits between the RGB capture/readback stages and the pupil-search thresholding stage.

---
 rtl/luma_pkg.sv | 22 ++
 rtl/luma_mac.sv | 39 +++
 rtl/luma_arbiter.sv | 116 +++++++++++
 tb/tb_luma_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/luma_pkg.sv
// Shared constants and FSM encoding for the luma arbiter slice.
// Coefficients are ITU-R BT.601 weights scaled by 256.
package luma_pkg;

  localparam int unsigned PIX_W  = 10;
  localparam int unsigned COEF_W = 8;
  localparam int unsigned ACC_W  = 18;
  localparam int unsigned SHIFT  = 8;

  localparam logic [COEF_W-1:0] COEF_R = 8'd77;
  localparam logic [COEF_W-1:0] COEF_G = 8'd151;
  localparam logic [COEF_W-1:0] COEF_B = 8'd28;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StMulR = 3'd1;
  localparam state_t StMulG = 3'd2;
  localparam state_t StMulB = 3'd3;
  localparam state_t StOut  = 3'd4;

endpackage

// File: rtl/luma_mac.sv
// Single 10x8 unsigned multiplier feeding an 18-bit accumulator.
// iCLR selects load-product versus accumulate when iEN is high.
module luma_mac
  import luma_pkg::*;
(
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iEN,
  input  logic              iCLR,
  input  logic [PIX_W-1:0]  iOPERAND,
  input  logic [COEF_W-1:0] iCOEF,
  output logic [PIX_W-1:0]  oLUMA
);

  logic [ACC_W-1:0] product;
  logic [ACC_W-1:0] accD;
  logic [ACC_W-1:0] accQ;

  assign product = {8'b0, iOPERAND} * {10'b0, iCOEF};

  always_comb begin
    accD = accQ;
    if (iEN) begin
      accD = iCLR ? product : accQ + product;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      accQ <= '0;
    end else begin
      accQ <= accD;
    end
  end

  // Truncating shift: the sum peaks at 1023*256, so the top bits never overflow.
  assign oLUMA = accQ[ACC_W-1:SHIFT];

endmodule

// File: rtl/luma_arbiter.sv
// Two-requester arbiter around one sequential RGB-to-luma engine.
// FIXED_PRIORITY = 0 alternates under contention; 1 always favours requester 0.
module luma_arbiter
  import luma_pkg::*;
#(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iVALID0,
  input  logic [PIX_W-1:0] iR0,
  input  logic [PIX_W-1:0] iG0,
  input  logic [PIX_W-1:0] iB0,
  input  logic             iVALID1,
  input  logic [PIX_W-1:0] iR1,
  input  logic [PIX_W-1:0] iG1,
  input  logic [PIX_W-1:0] iB1,
  output logic             oREADY0,
  output logic             oREADY1,
  output logic             oVALID,
  output logic [PIX_W-1:0] oDATA,
  output logic             oID,
  input  logic             iREADY
);

  localparam bit RoundRobin = (FIXED_PRIORITY == 0);

  state_t stateQ, stateD;
  logic lastQ;
  logic idQ;
  logic [PIX_W-1:0] rQ, gQ, bQ;

  logic idle, grant0, grant1, xfer;
  logic macEn, macClr;
  logic [PIX_W-1:0] macOp;
  logic [COEF_W-1:0] macCoef;

  assign idle = (stateQ == StIdle);

  // Requester 1 wins alone, or under contention when requester 0 was served last.
  assign grant1  = iVALID1 & (~iVALID0 | (RoundRobin & ~lastQ));
  assign grant0  = iVALID0 & ~grant1;
  assign oREADY0 = idle & grant0;
  assign oREADY1 = idle & grant1;
  assign xfer    = oREADY0 | oREADY1;

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (xfer) stateD = StMulR;
      StMulR:  stateD = StMulG;
      StMulG:  stateD = StMulB;
      StMulB:  stateD = StOut;
      StOut:   if (iREADY) stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    macEn   = 1'b0;
    macClr  = 1'b0;
    macOp   = rQ;
    macCoef = COEF_R;
    unique case (stateQ)
      StMulR: begin
        macEn  = 1'b1;
        macClr = 1'b1;
      end
      StMulG: begin
        macEn   = 1'b1;
        macOp   = gQ;
        macCoef = COEF_G;
      end
      StMulB: begin
        macEn   = 1'b1;
        macOp   = bQ;
        macCoef = COEF_B;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      stateQ <= StIdle;
      lastQ  <= 1'b1;
      idQ    <= 1'b0;
      rQ     <= '0;
      gQ     <= '0;
      bQ     <= '0;
    end else begin
      stateQ <= stateD;
      if (xfer) begin
        lastQ <= grant1;
        idQ   <= grant1;
        rQ    <= grant1 ? iR1 : iR0;
        gQ    <= grant1 ? iG1 : iG0;
        bQ    <= grant1 ? iB1 : iB0;
      end
    end
  end

  luma_mac uMac (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iEN      (macEn),
    .iCLR     (macClr),
    .iOPERAND (macOp),
    .iCOEF    (macCoef),
    .oLUMA    (oDATA)
  );

  assign oVALID = (stateQ == StOut);
  assign oID    = idQ;

endmodule

// File: tb/tb_luma_arbiter.sv
// Directed bench for luma_arbiter: one round-robin and one fixed-priority
// instance share all stimulus; outputs are sampled 1 time unit after negedge.
module tb_luma_arbiter;

  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  logic iRST, iVALID0, iVALID1, iREADY;
  logic [9:0] iR0, iG0, iB0, iR1, iG1, iB1;

  logic rrReady0, rrReady1, rrValid, rrId;
  logic [9:0] rrData;
  logic fpReady0, fpReady1, fpValid, fpId;
  logic [9:0] fpData;

  int nChecks = 0;
  int nErrors = 0;
  int cycleCnt = 0;

  always @(posedge iCLK) cycleCnt <= cycleCnt + 1;

  luma_arbiter #(.FIXED_PRIORITY(0)) dutRr (
    .iCLK (iCLK), .iRST (iRST),
    .iVALID0 (iVALID0), .iR0 (iR0), .iG0 (iG0), .iB0 (iB0),
    .iVALID1 (iVALID1), .iR1 (iR1), .iG1 (iG1), .iB1 (iB1),
    .oREADY0 (rrReady0), .oREADY1 (rrReady1),
    .oVALID (rrValid), .oDATA (rrData), .oID (rrId), .iREADY (iREADY)
  );

  luma_arbiter #(.FIXED_PRIORITY(1)) dutFp (
    .iCLK (iCLK), .iRST (iRST),
    .iVALID0 (iVALID0), .iR0 (iR0), .iG0 (iG0), .iB0 (iB0),
    .iVALID1 (iVALID1), .iR1 (iR1), .iG1 (iG1), .iB1 (iB1),
    .oREADY0 (fpReady0), .oREADY1 (fpReady1),
    .oVALID (fpValid), .oDATA (fpData), .oID (fpId), .iREADY (iREADY)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    iRST = 1'b0;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b1;
    #1;
  endtask

  // Present one pixel on the round-robin DUT, then check latency, data and ID.
  task automatic sendPixel(input logic req, input logic [9:0] r, input logic [9:0] g,
                           input logic [9:0] b, input logic [9:0] expData, input string tag,
                           output int xferCycle);
    int n;
    int lat;
    xferCycle = 0;
    if (req) begin
      iVALID1 = 1'b1; iR1 = r; iG1 = g; iB1 = b;
    end else begin
      iVALID0 = 1'b1; iR0 = r; iG0 = g; iB0 = b;
    end
    #1;
    n = 0;
    while (!(req ? rrReady1 : rrReady0) && n < 10) begin
      @(negedge iCLK); #1; n++;
    end
    checkEq({tag, "_ready"}, req ? rrReady1 : rrReady0, 1);
    if (!(req ? rrReady1 : rrReady0)) begin
      iVALID0 = 1'b0; iVALID1 = 1'b0;
      return;
    end
    @(posedge iCLK);
    xferCycle = cycleCnt;
    @(negedge iCLK);
    // Drop valid and scramble operands: the captured pixel must be unaffected.
    iVALID0 = 1'b0; iVALID1 = 1'b0;
    iR0 = r ^ 10'h2aa; iG0 = g ^ 10'h155; iB0 = b ^ 10'h3c3;
    iR1 = r ^ 10'h2aa; iG1 = g ^ 10'h155; iB1 = b ^ 10'h3c3;
    #1;
    checkEq({tag, "_busyRdy"}, {30'b0, rrReady0, rrReady1}, 0);
    lat = 0;
    while (!rrValid && lat < 10) begin
      @(posedge iCLK); @(negedge iCLK); #1; lat++;
    end
    checkEq({tag, "_latency"}, lat, 3);
    checkEq({tag, "_data"}, rrData, expData);
    checkEq({tag, "_id"}, rrId, req);
  endtask

  task automatic acceptStep(input string tag);
    @(posedge iCLK); @(negedge iCLK); #1;
    checkEq({tag, "_validDrop"}, rrValid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rrGnt[$];
    logic rrIds[$];
    logic [9:0] rrVals[$];
    logic fpIds[$];
    logic [9:0] fpVals[$];
    int fpGnt1Cnt;
    int t0, t1, t2, t3;
    int extra;

    iRST = 1'b0; iREADY = 1'b1;
    iVALID0 = 1'b0; iVALID1 = 1'b0;
    iR0 = '0; iG0 = '0; iB0 = '0; iR1 = '0; iG1 = '0; iB1 = '0;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK); #1;
    checkEq("rst_valid", rrValid, 0);
    checkEq("rst_data", rrData, 0);
    checkEq("rst_id", rrId, 0);
    checkEq("rst_fpValid", fpValid, 0);
    iRST = 1'b1;
    #1;

    // White pixel from the camera path.
    sendPixel(1'b0, 10'd1023, 10'd1023, 10'd1023, 10'd1023, "white", t0);
    acceptStep("white");

    // Primaries from the readback path, back to back.
    sendPixel(1'b1, 10'd1023, 10'd0, 10'd0, 10'd307, "red", t1);
    acceptStep("red");
    sendPixel(1'b1, 10'd0, 10'd1023, 10'd0, 10'd603, "green", t2);
    acceptStep("green");
    sendPixel(1'b1, 10'd0, 10'd0, 10'd1023, 10'd111, "blue", t3);
    acceptStep("blue");
    checkEq("spacing_rg", t2 - t1, 5);
    checkEq("spacing_gb", t3 - t2, 5);

    // Continuous contention after reset on both instances.
    doReset();
    iR0 = 10'd100; iG0 = 10'd200; iB0 = 10'd300;
    iR1 = 10'd512; iG1 = 10'd256; iB1 = 10'd128;
    iVALID0 = 1'b1; iVALID1 = 1'b1;
    fpGnt1Cnt = 0;
    #1;
    for (int i = 0; i < 22; i++) begin
      if (rrReady0 | rrReady1) rrGnt.push_back(rrReady1);
      if (rrValid) begin
        rrIds.push_back(rrId);
        rrVals.push_back(rrData);
      end
      if (fpReady1) fpGnt1Cnt++;
      if (fpValid) begin
        fpIds.push_back(fpId);
        fpVals.push_back(fpData);
      end
      @(posedge iCLK); @(negedge iCLK); #1;
    end
    iVALID0 = 1'b0; iVALID1 = 1'b0;
    checkEq("rr_gntCount", rrGnt.size() >= 4, 1);
    checkEq("rr_resCount", rrIds.size() >= 4, 1);
    checkEq("fp_resCount", fpIds.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < rrGnt.size()) checkEq($sformatf("rr_gnt%0d", i), rrGnt[i], i % 2);
      if (i < rrIds.size()) begin
        checkEq($sformatf("rr_id%0d", i), rrIds[i], i % 2);
        checkEq($sformatf("rr_data%0d", i), rrVals[i], (i % 2) ? 319 : 180);
      end
      if (i < fpIds.size()) begin
        checkEq($sformatf("fp_id%0d", i), fpIds[i], 0);
        checkEq($sformatf("fp_data%0d", i), fpVals[i], 180);
      end
    end
    checkEq("fp_gnt1", fpGnt1Cnt, 0);

    // Backpressure held for 7 cycles with both requesters asking.
    doReset();
    iREADY = 1'b0;
    sendPixel(1'b0, 10'd100, 10'd200, 10'd300, 10'd180, "bp", t0);
    iVALID0 = 1'b1; iVALID1 = 1'b1;
    iR0 = 10'd5; iG0 = 10'd6; iB0 = 10'd7; iR1 = 10'd8; iG1 = 10'd9; iB1 = 10'd10;
    for (int i = 0; i < 7; i++) begin
      @(posedge iCLK); @(negedge iCLK); #1;
      checkEq($sformatf("bp_valid%0d", i), rrValid, 1);
      checkEq($sformatf("bp_data%0d", i), rrData, 180);
      checkEq($sformatf("bp_id%0d", i), rrId, 0);
      checkEq($sformatf("bp_rdy%0d", i), {30'b0, rrReady0, rrReady1}, 0);
    end
    iREADY = 1'b1;
    @(posedge iCLK); @(negedge iCLK); #1;
    checkEq("bp_release", rrValid, 0);
    checkEq("bp_nextGnt", {30'b0, rrReady0, rrReady1}, 1);
    iVALID0 = 1'b0; iVALID1 = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge iCLK); @(negedge iCLK); #1;
      if (rrValid) extra++;
    end
    checkEq("bp_noExtra", extra, 0);

    // Reset while the engine is in the green term.
    iVALID1 = 1'b1; iR1 = 10'd1023; iG1 = 10'd0; iB1 = 10'd0;
    #1;
    checkEq("abort_ready", rrReady1, 1);
    @(posedge iCLK); @(negedge iCLK);
    iVALID1 = 1'b0;
    @(posedge iCLK); @(negedge iCLK); #1;
    checkEq("abort_preData", rrData, 307);
    iRST = 1'b0;
    @(posedge iCLK); @(negedge iCLK); #1;
    checkEq("abort_valid", rrValid, 0);
    checkEq("abort_data", rrData, 0);
    checkEq("abort_id", rrId, 0);
    checkEq("abort_rdy", {30'b0, rrReady0, rrReady1}, 0);
    iRST = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge iCLK); @(negedge iCLK); #1;
      if (rrValid) extra++;
    end
    checkEq("abort_noResult", extra, 0);
    sendPixel(1'b1, 10'd0, 10'd1023, 10'd0, 10'd603, "postRst", t0);
    acceptStep("postRst");

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
